// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Includes the state encoding, the slice width and the sizing of the nibble index.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The nibble index is at least one bit wide, even when there is a single slice.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/fullAdder.sv
// Existing 4-bit adder datapath slice: {cOut, sum} = a + b + cIn.
module fullAdder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cIn,
    output logic [3:0] sum,
    output logic       cOut
);

    assign {cOut, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cIn};

endmodule

// File: rtl/serial_add_ctrl.sv
// Wide adder built from one 4-bit fullAdder. It adds one nibble per clock, starting with the LSB.
// Define SERIAL_ADD_SUB_EN to add the sub port, which selects a - b.
//
// state   | meaning
// ST_IDLE | waiting for start; operands are latched on an accepted start
// ST_RUN  | one nibble per clock; carry is chained through a register
// ST_DONE | one-cycle done pulse; sum/cOut hold the completed result
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         Clk_s,
    input  logic         Rst_s,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cIn,
`ifdef SERIAL_ADD_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cOut
);

    localparam int              IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t state, state_nxt;

    logic [NIBBLES-1:0][NIBBLE_W-1:0] op_a, op_b, acc, acc_nxt;
    logic                             carry;
    logic [IDX_W-1:0]                 idx;
    logic [NIBBLE_W-1:0]              nib_sum;
    logic                             nib_cout;
    logic                             last_nib;
    logic [W-1:0]                     b_cap;
    logic                             c_cap;

    fullAdder u_fa (
        .a    (op_a[idx]),
        .b    (op_b[idx]),
        .cIn  (carry),
        .sum  (nib_sum),
        .cOut (nib_cout)
    );

    assign last_nib = (idx == IDX_LAST);

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: invert B and force the initial carry to 1.
    assign b_cap = sub ? ~b : b;
    assign c_cap = sub ? 1'b1 : cIn;
`else
    assign b_cap = b;
    assign c_cap = cIn;
`endif

    always_ff @(posedge Clk_s or posedge Rst_s) begin
        if (Rst_s) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (last_nib) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The accumulator after this cycle's nibble. Publishing it as one word keeps sum free of partial results.
    always_comb begin
        acc_nxt      = acc;
        acc_nxt[idx] = nib_sum;
    end

    always_ff @(posedge Clk_s or posedge Rst_s) begin
        if (Rst_s) begin
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cOut  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b_cap;
                        carry <= c_cap;
                        idx   <= '0;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_nxt;
                    carry <= nib_cout;
                    if (last_nib) begin
                        sum  <= acc_nxt;
                        cOut <= nib_cout;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Sequencer that performs wide (4*NIBBLES-bit) addition by time-multiplexing a single 4-bit fullAdder, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles through a register.
- Start/busy/done handshake.
- Sits between a requester (bench or future ALU control) and the existing 4-bit adder datapath.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- Clk_s  input  1  system clock, all state updates on rising edge
- Rst_s  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  W  operand A; captured on accepted start
- b  input  W  operand B; captured on accepted start
- cIn  input  1  carry-in; captured on accepted start
- sub  input  1  subtract select; present only when SERIAL_ADD_SUB_EN is defined
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  W  last completed result
- cOut  output  1  final carry of last completed result

Behaviour:
- Reset, asynchronous on Rst_s high: state=IDLE; busy=0, done=0, sum=0, cOut=0; internal operand, accumulator, carry and index registers all cleared.
- States: IDLE, RUN, DONE (encoding in package).
- IDLE:
  - If start=1 at edge E0: latch a, b, cIn into opA, opB, carry; idx=0; go to RUN.
  - If start=0: stay in IDLE.
- RUN, each edge:
  - Adder inputs: opA[4*idx+:4], opB[4*idx+:4], carry.
  - Registered on the edge: acc[4*idx+:4] <= adder sum; carry <= adder cOut.
  - If idx==NIBBLES-1: copy acc (including the new nibble) to sum, copy the final carry to cOut, go to DONE.
  - Otherwise idx <= idx+1.
- DONE: done=1 for exactly one cycle; go to IDLE on the next edge.
- Latency: start edge E0; nibble k registered at edge E(k+1); done high during the cycle after E(NIBBLES). Throughput: one operation per NIBBLES+2 cycles.
- sum/cOut change only at the RUN->DONE transition and hold until the next completion; never partial.
- start while busy (RUN or DONE) is ignored, not queued; a/b/cIn changes after capture have no effect.
- Arithmetic is modulo 2^W; cOut is the carry out of bit W-1. There is no overflow flag.
- NIBBLES=1: exactly one RUN cycle; done follows at E1.
- Reset asserted mid-RUN aborts the operation; sum/cOut return to 0 and there is no done pulse.
- idx width = max(1, clog2(NIBBLES)); idx never exceeds NIBBLES-1.

Optional Feature:
- Macro SERIAL_ADD_SUB_EN.
- Defined:
  - sub port exists; captured with the operands.
  - When captured sub=1: opB is stored as ~b and the initial carry is forced to 1 (cIn ignored), so result = a - b mod 2^W.
  - cOut=1 means no borrow.
- Undefined: no sub port; always addition using cIn.

Decomposition:
- Package serial_add_pkg: state enumeration constants (ST_IDLE, ST_RUN, ST_DONE), NIBBLE_W=4, helper function for the idx width.
- Sub-module: reuse the existing fullAdder (4-bit a, b, cIn -> sum, cOut) as the single instance. No new sub-module.

Test Plan:
- NIBBLES=4, a=16'h000B, b=16'h0003, cIn=0, start pulse -> done 4 cycles after the start edge; sum=16'h000E, cOut=0; busy high 5 cycles.
- a=16'h0FFF, b=16'h0001, cIn=0 -> sum=16'h1000, cOut=0 (carry ripples across three nibbles).
- a=16'hFFFF, b=16'h0000, cIn=1 -> sum=16'h0000, cOut=1. Then start held high during RUN with new a/b -> ignored; sum stays 0000 until the next IDLE start.
- Rst_s pulsed at RUN idx=2 -> state IDLE, sum=0, cOut=0, busy=0 immediately; no done pulse. A following start with a=16'h1234, b=16'h4321 -> sum=16'h5555.
- SERIAL_ADD_SUB_EN defined: a=16'h0005, b=16'h0007, sub=1 -> sum=16'hFFFE, cOut=0. a=16'h0007, b=16'h0005, sub=1 -> sum=16'h0002, cOut=1.
- NIBBLES=1: a=4'hB, b=4'h3, cIn=0 -> done at E1 cycle; sum=4'hE, cOut=0.
